// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width plus load/store size codes and LSU FSM states.
// lsu_misaligned() flags half accesses on odd bytes and word accesses off a word boundary.
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int LSU_BE_W = XLEN / 8;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  // funct3[1] set means word (including the unassigned 011/110/111 codes).
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    if (funct3[1]) begin
      return addr_lo != 2'b00;
    end
    if (funct3[0]) begin
      return addr_lo[0];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational lane formatter: store byte enables and lane-replicated write data,
// and load lane selection with sign/zero extension. No state, zero latency.
module lsu_fmt
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int BE_W = riscv_pkg::LSU_BE_W
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [BE_W-1:0] o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] w_bshift;
  logic [XLEN-1:0] w_hshift;
  logic            w_signed;

  assign w_bshift = i_rdata >> {i_addr_lo, 3'b000};
  assign w_hshift = i_rdata >> {i_addr_lo[1], 4'b0000};
  assign w_signed = ~i_funct3[2];

  always_comb begin
    o_be    = '1;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (lsu_size_e'(i_funct3))
      LB, LBU: begin
        o_be    = BE_W'(1) << i_addr_lo;
        o_wdata = {BE_W{i_wdata[7:0]}};
        o_rdata = {{(XLEN-8){w_signed & w_bshift[7]}}, w_bshift[7:0]};
      end
      LH, LHU: begin
        o_be    = BE_W'(3) << {i_addr_lo[1], 1'b0};
        o_wdata = {(XLEN/16){i_wdata[15:0]}};
        o_rdata = {{(XLEN-16){w_signed & w_hshift[15]}}, w_hshift[15:0]};
      end
      default: begin
        o_be    = '1;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one core access -> one valid/ready bus request (+ read response for loads).
// Store >= 2 stall cycles, load >= 3; bus timeout after TIMEOUT_CYCLES. LSU_MISALIGN_TRAP_EN enables misalign aborts.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN           = riscv_pkg::XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_misalign,
  output logic              o_bus_err,
  output logic              o_bus_valid,
  input  logic              i_bus_ready,
  output logic [XLEN-1:0]   o_bus_addr,
  output logic              o_bus_we,
  output logic [XLEN/8-1:0] o_bus_be,
  output logic [XLEN-1:0]   o_bus_wdata,
  input  logic              i_bus_rvalid,
  input  logic [XLEN-1:0]   i_bus_rdata
);

  localparam int BE_W  = XLEN / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e      r_state;
  logic [XLEN-1:0] r_addr;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [BE_W-1:0] r_be;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic            r_valid;
  logic            r_done;
  logic            r_misalign;
  logic            r_bus_err;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]      w_fmt_funct3;
  logic [1:0]      w_fmt_addr;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wdata_rep;
  logic [XLEN-1:0] w_rdata_ext;
  logic            w_misalign;
  logic            w_timeout;

  // The formatter sees the live core request while idle and the latched one afterwards.
  assign w_fmt_funct3 = (r_state == IDLE) ? i_funct3 : r_funct3;
  assign w_fmt_addr   = (r_state == IDLE) ? i_addr[1:0] : r_addr[1:0];

  lsu_fmt #(
    .XLEN (XLEN),
    .BE_W (BE_W)
  ) u_fmt (
    .i_funct3  (w_fmt_funct3),
    .i_addr_lo (w_fmt_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_bus_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = lsu_misaligned(i_funct3, i_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_be       <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req) begin
            if (w_misalign) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
              r_rdata    <= '0;
            end else begin
              r_state  <= REQ;
              r_valid  <= 1'b1;
              r_cnt    <= '0;
              r_addr   <= i_addr;
              r_we     <= i_we;
              r_funct3 <= i_funct3;
              r_be     <= w_be;
              r_wdata  <= w_wdata_rep;
            end
          end
        end
        REQ: begin
          if (i_bus_ready) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            if (r_we) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end else if (w_timeout) begin
            r_valid   <= 1'b0;
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (i_bus_rvalid) begin
            r_rdata <= w_rdata_ext;
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_misalign <= 1'b0;
          r_bus_err  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by reset so the stall also reads 0 while the core still drives i_req.
  assign o_stall     = i_rst & i_req & (r_state != DONE);
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_misalign  = r_misalign;
  assign o_bus_err   = r_bus_err;
  assign o_bus_valid = r_valid;
  assign o_bus_addr  = {r_addr[XLEN-1:2], 2'b00};
  assign o_bus_we    = r_we;
  assign o_bus_be    = r_be;
  assign o_bus_wdata = r_wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: transaction-level reference model with per-cycle output expectations,
// directed scenarios with literal values, then randomized accesses with bus delays and timeouts.
module tb_riscv_lsu;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic        o_stall, o_done, o_misalign, o_bus_err, o_bus_valid, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_ready = 1'b0, i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  always #5 clk = ~clk;

  riscv_lsu #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_done(o_done),
    .o_rdata(o_rdata), .o_misalign(o_misalign), .o_bus_err(o_bus_err),
    .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready), .o_bus_addr(o_bus_addr),
    .o_bus_we(o_bus_we), .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  logic exp_stall, exp_done, exp_valid, exp_mis, exp_err, exp_we, bus_chk;
  logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  int tot_stall = 0, tot_done = 0, tot_valid = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0, cap_rdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_err = 1'b0, cap_mis = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: dut=%h model=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: access size in bytes, lane offset, and lane arithmetic.
  function automatic int msize(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int moff(input logic [2:0] f3, input logic [31:0] a);
    int sz = msize(f3);
    if (sz == 4) return 0;
    if (sz == 2) return int'(a[1]) * 2;
    return int'(a[1:0]);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] b = '0;
    int sz = msize(f3);
    int off = moff(f3, a);
    for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + sz);
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz = msize(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int sz = msize(f3);
    logic [31:0] v, mask;
    if (sz == 4) return rd;
    v = rd >> (8 * moff(f3, a));
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v = v & mask;
    if (f3[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    int sz = msize(f3);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
  endfunction

  task automatic set_defaults();
    exp_done = 1'b0; exp_mis = 1'b0; exp_err = 1'b0; exp_valid = 1'b0; bus_chk = 1'b0;
    i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = $urandom;
  endtask

  // Compare outputs at the falling edge, then advance to just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (chk_en) begin
      check("stall", 32'(o_stall), 32'(exp_stall));
      check("done", 32'(o_done), 32'(exp_done));
      check("bus_valid", 32'(o_bus_valid), 32'(exp_valid));
      check("misalign", 32'(o_misalign), 32'(exp_mis));
      check("bus_err", 32'(o_bus_err), 32'(exp_err));
      check("rdata", o_rdata, exp_rdata);
      if (bus_chk) begin
        check("bus_addr", o_bus_addr, exp_addr);
        check("bus_we", 32'(o_bus_we), 32'(exp_we));
        check("bus_be", 32'(o_bus_be), 32'(exp_be));
        check("bus_wdata", o_bus_wdata, exp_wdata);
      end
      tot_stall += int'(o_stall);
      tot_done  += int'(o_done);
      tot_valid += int'(o_bus_valid);
      if (o_bus_valid) begin
        cap_addr = o_bus_addr; cap_be = o_bus_be; cap_wdata = o_bus_wdata;
      end
      if (o_done) begin
        cap_rdata = o_rdata; cap_err = o_bus_err; cap_mis = o_misalign;
      end
    end
    @(posedge clk);
    #1;
    set_defaults();
  endtask

  task automatic req_drive(input bit drop);
    if (drop) begin
      i_req    = ($urandom_range(0, 2) != 0);
      i_addr   = $urandom;
      i_wdata  = $urandom;
      i_funct3 = 3'($urandom_range(0, 7));
      i_we     = 1'($urandom_range(0, 1));
    end else begin
      i_req = 1'b1;
    end
  endtask

  task automatic idle();
    i_req = 1'b0;
    exp_stall = 1'b0;
    cycle();
  endtask

  // rdly: REQ cycles with ready low before ready; vdly: WAIT cycles before rvalid (>= T times out).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int rdly, input int vdly, input bit drop);
    bit mis = 0;
    bit acc = 0;
    bit tmo = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = m_mis(f3, addr);
`endif
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
    exp_stall = 1'b1;
    cycle();
    if (mis) begin
      req_drive(drop);
      exp_stall = 1'b0; exp_done = 1'b1; exp_mis = 1'b1; exp_rdata = '0;
      cycle();
      return;
    end
    for (int k = 0; k < T && !acc; k++) begin
      req_drive(drop);
      exp_stall = i_req; exp_valid = 1'b1; bus_chk = 1'b1;
      exp_addr = addr & ~32'h3; exp_we = we; exp_be = m_be(f3, addr); exp_wdata = m_wdata(f3, wd);
      if (k == rdly) begin
        i_bus_ready = 1'b1;
        i_bus_rvalid = 1'($urandom_range(0, 1));
        acc = 1;
      end
      cycle();
    end
    if (!acc) begin
      tmo = 1;
    end else if (!we) begin
      acc = 0;
      for (int k = 0; k < T && !acc; k++) begin
        req_drive(drop);
        exp_stall = i_req;
        if (k == vdly) begin
          i_bus_rvalid = 1'b1;
          i_bus_rdata = rd;
          acc = 1;
        end
        cycle();
      end
      if (!acc) tmo = 1;
    end
    req_drive(drop);
    i_bus_rvalid = 1'($urandom_range(0, 1));
    exp_stall = 1'b0; exp_done = 1'b1; exp_err = tmo;
    if (tmo) exp_rdata = '0;
    else if (!we) exp_rdata = m_load(f3, addr, rd);
    cycle();
  endtask

  function automatic int rnd_delay();
    int r = int'($urandom_range(0, 9));
    if (r < 7) return r % 3;
    if (r == 9) return T + 5;
    return int'($urandom_range(3, T - 1));
  endfunction

  initial begin
    int s0, d0, v0;
    set_defaults();
    exp_stall = 1'b0;
    i_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 32'(o_stall), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_valid", 32'(o_bus_valid), 32'd0);
    check("reset_rdata", o_rdata, 32'd0);
    i_req = 1'b0;
    rst_n = 1'b1;
    chk_en = 1;
    idle();

    // SB to 0x103: byte lane 3, replicated data, two stall cycles.
    s0 = tot_stall; d0 = tot_done;
    run_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 0);
    check("t1_addr", cap_addr, 32'h100);
    check("t1_be", 32'(cap_be), 32'h8);
    check("t1_wdata", cap_wdata, 32'hA5A5A5A5);
    check("t1_stalls", 32'(tot_stall - s0), 32'd2);
    check("t1_done", 32'(tot_done - d0), 32'd1);
    idle();

    run_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 0, 2, 0);
    check("t2_lb", cap_rdata, 32'hFFFFFF80);
    s0 = tot_stall;
    run_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 0, 0, 0);
    check("t2_lbu", cap_rdata, 32'h00000080);
    check("t2_stalls", 32'(tot_stall - s0), 32'd3);

    run_txn(1'b0, 3'b001, 32'h202, 32'h0, 32'h80011234, 0, 1, 0);
    check("t3_lh", cap_rdata, 32'hFFFF8001);
    v0 = tot_valid;
    run_txn(1'b0, 3'b010, 32'h200, 32'h0, 32'hDEADBEEF, 4, 0, 0);
    check("t3_lw", cap_rdata, 32'hDEADBEEF);
    check("t3_valid_cycles", 32'(tot_valid - v0), 32'd5);

    v0 = tot_valid;
    run_txn(1'b0, 3'b010, 32'h204, 32'h0, 32'h12345678, T + 10, 0, 0);
    check("t4_valid_cycles", 32'(tot_valid - v0), 32'd8);
    check("t4_err", 32'(cap_err), 32'd1);
    check("t4_rdata", cap_rdata, 32'd0);

    v0 = tot_valid;
    run_txn(1'b0, 3'b001, 32'h101, 32'h0, 32'hCAFE8765, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("t5_mis", 32'(cap_mis), 32'd1);
    check("t5_no_bus", 32'(tot_valid - v0), 32'd0);
`else
    check("t5_be", 32'(cap_be), 32'h3);
    check("t5_rdata", cap_rdata, 32'hFFFF8765);
`endif

    for (int n = 0; n < 250; n++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              rnd_delay(), rnd_delay(), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) idle();
    end

    // Reset asserted while a load waits for its response.
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h300; i_wdata = 32'h0;
    exp_stall = 1'b1;
    cycle();
    exp_stall = 1'b1; exp_valid = 1'b1; bus_chk = 1'b1;
    exp_addr = 32'h300; exp_we = 1'b0; exp_be = m_be(3'b010, 32'h300); exp_wdata = m_wdata(3'b010, 32'h0);
    i_bus_ready = 1'b1;
    cycle();
    #2;
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    check("t6_stall", 32'(o_stall), 32'd0);
    check("t6_done", 32'(o_done), 32'd0);
    check("t6_rdata", o_rdata, 32'd0);
    check("t6_mis", 32'(o_misalign), 32'd0);
    check("t6_err", 32'(o_bus_err), 32'd0);
    check("t6_valid", 32'(o_bus_valid), 32'd0);
    check("t6_addr", o_bus_addr, 32'd0);
    check("t6_we", 32'(o_bus_we), 32'd0);
    check("t6_be", 32'(o_bus_be), 32'd0);
    check("t6_wdata", o_bus_wdata, 32'd0);
    i_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_rdata = '0;
    set_defaults();
    chk_en = 1;
    idle();

    d0 = tot_done;
    run_txn(1'b1, 3'b010, 32'h400, 32'h11223344, 32'h0, 0, 0, 0);
    check("t6_sw_be", 32'(cap_be), 32'hF);
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h55667788, 0, 0, 0);
    check("t6_lw", cap_rdata, 32'h55667788);
    check("t6_b2b_done", 32'(tot_done - d0), 32'd2);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit sitting directly downstream of the single-cycle datapath's data-memory port (data address, write data, read data).
- Converts one core memory request into one data-bus transaction with a valid/ready request and a separate read-response handshake.
- Formats byte enables and write lanes; sign- or zero-extends load data.
- Drives a stall so the core holds its PC until the access completes.

Parameters:
XLEN, riscv_pkg::XLEN (32), data and address width.
TIMEOUT_CYCLES, 255, number of bus cycles waited in REQ or WAIT before aborting with o_bus_err.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-low.
i_req  in  1  core presents a load/store this cycle.
i_we  in  1  1 = store, 0 = load.
i_funct3  in  3  RV32I size/sign code (lsu_size_e).
i_addr  in  XLEN  byte address (ALU result).
i_wdata  in  XLEN  store data (rs2).
o_stall  out  1  core must hold PC and register write.
o_done  out  1  one-cycle pulse: access finished, o_rdata valid for loads.
o_rdata  out  XLEN  extended load data.
o_misalign  out  1  misaligned access flag, valid with o_done.
o_bus_err  out  1  timeout flag, valid with o_done.
o_bus_valid  out  1  bus request valid.
i_bus_ready  in  1  bus accepts request.
o_bus_addr  out  XLEN  word-aligned address, addr[1:0] = 0.
o_bus_we  out  1  bus write.
o_bus_be  out  XLEN/8  byte enables.
o_bus_wdata  out  XLEN  lane-replicated write data.
i_bus_rvalid  in  1  read response valid.
i_bus_rdata  in  XLEN  read response word.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ on i_req when the access is aligned. Register addr, we, funct3, be and wdata.
  - REQ: o_bus_valid = 1 and bus outputs stay stable until i_bus_ready.
    - On ready with a store -> DONE.
    - On ready with a load -> WAIT.
  - WAIT: i_bus_rvalid is sampled only from the cycle after acceptance. On rvalid, capture the formatted data -> DONE.
  - DONE: o_done = 1 and o_stall = 0 for exactly one cycle, then -> IDLE unconditionally.
- o_stall = i_req && state != DONE, combinational.
- Minimum latency:
  - Store: 2 stall cycles.
  - Load: 3 stall cycles.
- Store formatting:
  - SB: be = 4'b0001 << addr[1:0], byte replicated to all 4 lanes.
  - SH: be = 4'b0011 << {addr[1],1'b0}, half replicated to both halves.
  - SW: be = 4'b1111.
- Load formatting:
  - LB/LBU select the byte lane at addr[1:0]; LH/LHU select the half at addr[1]; LW takes the full word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- funct3 values 011, 110 and 111 are treated as word accesses.
- Timeout: a counter clears on entry to REQ and on REQ->WAIT, and increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES:
  - o_bus_valid drops.
  - FSM -> DONE with o_bus_err = 1 and o_rdata = 0.
  - A late rvalid is ignored.
- o_rdata holds its value until the next capture. It is zeroed on timeout and on a misaligned abort.
- i_req low while in REQ or WAIT (core flushed): the transaction still completes and the done pulse is emitted.
- Reset, including mid-transaction: state = IDLE; every output 0 immediately (o_bus_valid drops asynchronously); counter = 0.

Optional Feature:
Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, is misaligned.
  - IDLE -> DONE directly with no bus transaction.
  - o_misalign = 1, o_rdata = 0.
- Undefined:
  - Misalignment is ignored: halfword lane = addr[1], word lane = 0.
  - o_misalign is tied to 0; all accesses go to the bus.

Decomposition:
- riscv_pkg gets the following additions:
  - lsu_size_e enum: LB = 3'b000, LH = 001, LW = 010, LBU = 100, LHU = 101.
  - lsu_state_e enum: IDLE, REQ, WAIT, DONE.
  - Constant LSU_BE_W = XLEN/8.
- One combinational sub-module, lsu_fmt:
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: be, lane-replicated wdata, extended rdata.
- riscv_lsu keeps the FSM, registers and timeout counter.

Test Plan:
1. SB, addr = 0x103, wdata = 0x000000A5, ready immediate -> o_bus_addr = 0x100, be = 4'b1000, wdata = 0xA5A5A5A5, 2 stall cycles, then a done pulse.
2. LB, addr = 0x102, rdata = 0x0080FF00, rvalid 3 cycles after acceptance -> o_rdata = 0xFFFFFF80. Repeat as LBU -> 0x00000080.
3. LH, addr = 0x202, rdata = 0x8001_1234 -> 0xFFFF8001. LW, addr = 0x200, ready held low 4 cycles -> bus outputs stable throughout, o_rdata = rdata.
4. LW with ready never asserted, TIMEOUT_CYCLES = 8 -> o_bus_valid drops after 8 cycles; done pulse with o_bus_err = 1, o_rdata = 0.
5. LH, addr = 0x101:
   - With LSU_MISALIGN_TRAP_EN: no o_bus_valid, o_misalign = 1 on the cycle after the request.
   - Without it: bus access with be = 4'b0011.
6. i_rst low during WAIT -> all outputs 0 immediately. After release, a new SW completes normally; back-to-back SW then LW yield two distinct done pulses.
